// File: rtl/pong_game_if.sv
// Pong controller bus: datapath events in, game-flow commands and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is a level or single-cycle pulse sampled each clk.
//
// master : the game controller (samples events, drives commands/status)
// slave  : the surrounding datapath / display / test environment
interface pong_game_if;
    logic       start_btn;   // start button level, already synchronous
    logic       miss_l;      // ball passed left edge (right player scores)
    logic       miss_r;      // ball passed right edge (left player scores)
    logic       paddle_hit;  // ball bounced off a paddle
    logic       move_en;     // one-cycle ball advance enable
    logic       ball_reset;  // one-cycle re-centre pulse
    logic       serve_dir;   // 1 = serve right, 0 = serve left
    logic [1:0] speed;       // ball step size
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] state;       // IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
    logic       game_over;

    modport master (
        input  start_btn, miss_l, miss_r, paddle_hit,
        output move_en, ball_reset, serve_dir, speed,
               score_l, score_r, state, game_over
    );

    modport slave (
        output start_btn, miss_l, miss_r, paddle_hit,
        input  move_en, ball_reset, serve_dir, speed,
               score_l, score_r, state, game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE->SERVE->PLAY->POINT->OVER flow, movement tick, scores, speed.
// Latency: every output is registered; an input event is reflected one clk later.
// Backpressure: none; events are sampled every cycle and ignored outside PLAY.
//
// Ports: clk, rst_n (synchronous, active-low), gif (pong_game_if.master):
//   in  start_btn, miss_l, miss_r, paddle_hit
//   out move_en, ball_reset, serve_dir, speed, score_l, score_r, state, game_over
module pong_game_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int WIN_SCORE   = 9,
    parameter int MAX_SPEED   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    pong_game_if.master  gif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [15:0] POINT_LAST = 16'(POINT_TICKS - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [1:0]  SPD_MAX    = 2'(MAX_SPEED);

    state_t      state_q, state_d;
    logic [15:0] tick_cnt, tick_cnt_d;
    logic [15:0] wait_cnt, wait_cnt_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [3:0]  score_l_inc, score_r_inc;
    logic [1:0]  speed_q, speed_d;
    logic        serve_dir_q, serve_dir_d;
    logic        move_en_q, move_en_d;
    logic        ball_reset_q, ball_reset_d;
    logic        game_over_q, game_over_d;
    logic        start_q;
    logic        tick;
    logic        start_edge;

    always_comb begin
        tick         = (tick_cnt == TICK_LAST);
        start_edge   = gif.start_btn & ~start_q;
        tick_cnt_d   = tick ? 16'd0 : tick_cnt + 16'd1;
        score_l_inc  = score_l_q + 4'd1;
        score_r_inc  = score_r_q + 4'd1;

        state_d      = state_q;
        wait_cnt_d   = wait_cnt;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        speed_d      = speed_q;
        serve_dir_d  = serve_dir_q;
        move_en_d    = 1'b0;
        ball_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d      = ST_SERVE;
                    score_l_d    = 4'd0;
                    score_r_d    = 4'd0;
                    speed_d      = 2'd1;
                    serve_dir_d  = 1'b1;
                    wait_cnt_d   = 16'd0;
                    ball_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (wait_cnt == SERVE_LAST) begin
                        state_d    = ST_PLAY;
                        wait_cnt_d = 16'd0;
                    end else begin
                        wait_cnt_d = wait_cnt + 16'd1;
                    end
                end
            end
            ST_PLAY: begin
                // The tick that lands on a miss cycle still moves the ball.
                move_en_d = tick;
                if (gif.miss_l && gif.miss_r) begin
                    // Simultaneous misses: a void point, nobody scores.
                    state_d    = ST_POINT;
                    wait_cnt_d = 16'd0;
                end else if (gif.miss_l) begin
                    score_r_d   = score_r_inc;
                    serve_dir_d = 1'b0;
                    wait_cnt_d  = 16'd0;
                    state_d     = (score_r_inc == WIN) ? ST_OVER : ST_POINT;
                end else if (gif.miss_r) begin
                    score_l_d   = score_l_inc;
                    serve_dir_d = 1'b1;
                    wait_cnt_d  = 16'd0;
                    state_d     = (score_l_inc == WIN) ? ST_OVER : ST_POINT;
                end else if (gif.paddle_hit && (speed_q != SPD_MAX)) begin
                    speed_d = speed_q + 2'd1;
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (wait_cnt == POINT_LAST) begin
                        state_d      = ST_SERVE;
                        speed_d      = 2'd1;
                        wait_cnt_d   = 16'd0;
                        ball_reset_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so it lines up with the state output.
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt     <= 16'd0;
            wait_cnt     <= 16'd0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            speed_q      <= 2'd1;
            serve_dir_q  <= 1'b1;
            move_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt     <= tick_cnt_d;
            wait_cnt     <= wait_cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            speed_q      <= speed_d;
            serve_dir_q  <= serve_dir_d;
            move_en_q    <= move_en_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
            start_q      <= gif.start_btn;
        end
    end

    assign gif.state      = state_q;
    assign gif.move_en    = move_en_q;
    assign gif.ball_reset = ball_reset_q;
    assign gif.serve_dir  = serve_dir_q;
    assign gif.speed      = speed_q;
    assign gif.score_l    = score_l_q;
    assign gif.score_r    = score_r_q;
    assign gif.game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game flow plus randomized events, scoreboard-checked.
// Latency: expected outputs are due one clk after the inputs that produce them.
// Backpressure: none; stimulus is applied every cycle on the falling edge.
module tb_pong_game_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int SERVE_TICKS = 2;
    localparam int POINT_TICKS = 2;
    localparam int WIN_SCORE   = 3;
    localparam int MAX_SPEED   = 3;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_game_if gif();

    pong_game_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .SERVE_TICKS (SERVE_TICKS),
        .POINT_TICKS (POINT_TICKS),
        .WIN_SCORE   (WIN_SCORE),
        .MAX_SPEED   (MAX_SPEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gif   (gif)
    );

    typedef struct {
        int state;
        int move;
        int br;
        int dir;
        int speed;
        int sl;
        int sr;
        int go;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: game as seen by the players. since_rst counts clocks
    // since reset; every TICK_DIV-th clock is a movement tick.
    int m_state, m_ticks, m_sl, m_sr, m_speed, since_rst;
    int m_dir, m_move, m_br, m_prev_start;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input bit st, input bit ml, input bit mr, input bit ph);
        exp_t e;
        bit   is_tick;
        bit   pressed;
        if (!rn) begin
            m_state = S_IDLE; since_rst = 0; m_ticks = 0; m_sl = 0; m_sr = 0;
            m_speed = 1; m_dir = 1; m_move = 0; m_br = 0; m_prev_start = 0;
        end else begin
            is_tick      = (since_rst % TICK_DIV) == (TICK_DIV - 1);
            pressed      = st && (m_prev_start == 0);
            m_prev_start = st;
            since_rst++;
            m_move = (m_state == S_PLAY && is_tick) ? 1 : 0;
            m_br   = 0;
            if (m_state == S_IDLE || m_state == S_OVER) begin
                if (pressed) begin
                    m_state = S_SERVE; m_sl = 0; m_sr = 0; m_speed = 1;
                    m_dir = 1; m_ticks = 0; m_br = 1;
                end
            end else if (m_state == S_SERVE) begin
                if (is_tick) begin
                    m_ticks++;
                    if (m_ticks == SERVE_TICKS) begin
                        m_state = S_PLAY; m_ticks = 0;
                    end
                end
            end else if (m_state == S_PLAY) begin
                if (ml && mr) begin
                    m_state = S_POINT; m_ticks = 0;
                end else if (ml) begin
                    m_sr++; m_dir = 0; m_ticks = 0;
                    m_state = (m_sr == WIN_SCORE) ? S_OVER : S_POINT;
                end else if (mr) begin
                    m_sl++; m_dir = 1; m_ticks = 0;
                    m_state = (m_sl == WIN_SCORE) ? S_OVER : S_POINT;
                end else if (ph) begin
                    m_speed = (m_speed < MAX_SPEED) ? m_speed + 1 : MAX_SPEED;
                end
            end else if (m_state == S_POINT) begin
                if (is_tick) begin
                    m_ticks++;
                    if (m_ticks == POINT_TICKS) begin
                        m_state = S_SERVE; m_speed = 1; m_ticks = 0; m_br = 1;
                    end
                end
            end
        end
        e.state = m_state; e.move = m_move; e.br = m_br; e.dir = m_dir;
        e.speed = m_speed; e.sl = m_sl; e.sr = m_sr;
        e.go    = (m_state == S_OVER) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus, applied on the falling edge.
    task automatic step(input bit rn, input bit st, input bit ml, input bit mr, input bit ph);
        @(negedge clk);
        rst_n          = rn;
        gif.start_btn  = st;
        gif.miss_l     = ml;
        gif.miss_r     = mr;
        gif.paddle_hit = ph;
        model_step(rn, st, ml, mr, ph);
    endtask

    task automatic run_until(input int target, input int budget, input bit st);
        int n = 0;
        while (m_state != target && n < budget) begin
            step(1'b1, st, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_state != target) begin
            vectors++;
            miscompares++;
            $display("FAIL reach_state: stuck in %0d, wanted %0d", m_state, target);
        end
    endtask

    // Monitor: every clock the DUT presents a fresh set of registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",      int'(gif.state),      e.state);
                check("move_en",    int'(gif.move_en),    e.move);
                check("ball_reset", int'(gif.ball_reset), e.br);
                check("serve_dir",  int'(gif.serve_dir),  e.dir);
                check("speed",      int'(gif.speed),      e.speed);
                check("score_l",    int'(gif.score_l),    e.sl);
                check("score_r",    int'(gif.score_r),    e.sr);
                check("game_over",  int'(gif.game_over),  e.go);
            end
        end
    end

    initial begin
        bit st, ml, mr, ph, rn;
        int drain;
        rst_n = 1'b0; gif.start_btn = 1'b0; gif.miss_l = 1'b0;
        gif.miss_r = 1'b0; gif.paddle_hit = 1'b0;
        m_state = S_IDLE; since_rst = 0; m_ticks = 0; m_sl = 0; m_sr = 0;
        m_speed = 1; m_dir = 1; m_move = 0; m_br = 0; m_prev_start = 0;

        // Reset, then a quiet idle period.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start with the button held high: no re-trigger, play ticks follow.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until(S_PLAY, 40, 1'b1);
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Four paddle hits saturate speed, then the left player scores.
        repeat (4) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_until(S_SERVE, 40, 1'b0);
        run_until(S_PLAY, 40, 1'b0);

        // Miss beats a same-cycle hit; then a void double miss.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_until(S_SERVE, 40, 1'b0);
        run_until(S_PLAY, 40, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_until(S_SERVE, 40, 1'b0);
        run_until(S_PLAY, 40, 1'b0);

        // Left player runs out the game.
        for (int i = 0; i < 4 && m_state != S_OVER; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (m_state != S_OVER) begin
                run_until(S_SERVE, 40, 1'b0);
                run_until(S_PLAY, 40, 1'b0);
            end
        end
        run_until(S_OVER, 1, 1'b0);

        // Events in OVER are ignored; a fresh start edge begins a new game.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until(S_PLAY, 40, 1'b0);

        // Randomized play with occasional resets and button toggles.
        st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) st = ~st;
            ml = ($urandom_range(0, 19) == 0);
            mr = ($urandom_range(0, 19) == 0);
            ph = ($urandom_range(0, 7) == 0);
            step(rn, st, ml, mr, ph);
        end

        // Reset mid-PLAY with score_l at 2.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until(S_PLAY, 40, 1'b0);
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            run_until(S_SERVE, 40, 1'b0);
            run_until(S_PLAY, 40, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Let the monitor consume the remaining expectations.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game sequencer for the Pong datapath; owns the game flow IDLE → SERVE → PLAY → POINT → OVER.
- Generates the ball-movement tick from clk and gates it so the ball datapath moves only during PLAY.
- Keeps both players' scores and the rally speed level; commands ball re-centre and serve direction.
- Sits between the ball/paddle datapath, which reports miss/hit events, and the display/score logic.

Parameters:
- TICK_DIV, 50000: clk cycles per movement tick (≥2).
- SERVE_TICKS, 60: ticks held in SERVE before play starts (≥1).
- POINT_TICKS, 90: ticks held in POINT after a point (≥1).
- WIN_SCORE, 9: score that ends the game (1..15).
- MAX_SPEED, 3: saturation value of speed (1..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_btn  in  1  start button, level, already synchronous; rising edge used
- miss_l  in  1  ball passed left edge this cycle (right player scores)
- miss_r  in  1  ball passed right edge this cycle (left player scores)
- paddle_hit  in  1  ball bounced off a paddle this cycle
- move_en  out  1  one-cycle enable to advance ball position
- ball_reset  out  1  one-cycle pulse: re-centre ball
- serve_dir  out  1  1 = serve right, 0 = serve left
- speed  out  2  ball step size for datapath, 1..MAX_SPEED
- score_l  out  4  left score
- score_r  out  4  right score
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- game_over  out  1  high while in OVER

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, tick_cnt=0, wait_cnt=0, scores=0, move_en=0, ball_reset=0, serve_dir=1, speed=1, game_over=0, start edge register=0. Reset mid-game aborts immediately, with no pending pulses.
- All outputs are registered.
- Tick: 16-bit tick_cnt free-runs 0..TICK_DIV-1 and wraps to 0. Internal tick=1 when tick_cnt==TICK_DIV-1. The counter runs in every state.
- Start edge: start_btn=1 while previous sample was 0. It is honoured only in IDLE and OVER and ignored elsewhere.
- IDLE/OVER + start edge:
  - next state SERVE; scores cleared to 0; speed=1; serve_dir=1; wait_cnt=0.
  - ball_reset=1 in the following cycle only.
- SERVE:
  - miss/hit inputs ignored.
  - On each tick: if wait_cnt==SERVE_TICKS-1, go to PLAY and clear wait_cnt; otherwise increment wait_cnt.
- PLAY:
  - Tick → move_en=1 in the next cycle, one cycle wide. No move_en in any other state.
  - paddle_hit (no miss the same cycle) → speed+1, saturating at MAX_SPEED.
  - miss_l only → score_r+1 and serve_dir=0.
  - miss_r only → score_l+1 and serve_dir=1.
  - After a scoring miss: if the incremented score equals WIN_SCORE, go to OVER; else go to POINT with wait_cnt=0.
  - miss_l and miss_r in the same cycle → no score change, serve_dir unchanged, go to POINT.
  - A miss has priority over paddle_hit in the same cycle; the hit is dropped.
  - A miss coinciding with a tick: move_en is still issued for that tick.
- POINT:
  - Inputs ignored.
  - Counts ticks the same way as SERVE, using POINT_TICKS.
  - On expiry: go to SERVE, speed=1, wait_cnt=0, and ball_reset=1 for the next cycle.
- OVER: game_over=1; scores held; waits for a start edge.
- Scores never exceed WIN_SCORE and never wrap.

Test Plan (TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=2, WIN_SCORE=3, MAX_SPEED=3):
- Reset then idle 20 cycles → state=0, move_en never 1, scores 0, speed=1, serve_dir=1.
- Start_btn rising edge → ball_reset one-cycle pulse, state=1, state=2 after the 2nd tick. In PLAY, move_en pulses every 4 cycles, one cycle after each tick; start_btn held high gives no re-trigger.
- In PLAY: pulse paddle_hit 4 times → speed 2,3,3,3. Then miss_r → score_l=1, serve_dir=1, state=3, 2 ticks later ball_reset pulse, speed=1, state=1.
- miss_l and paddle_hit in the same cycle → score_r=1, serve_dir=0, speed unchanged. miss_l and miss_r in the same cycle → scores unchanged, state=3.
- Three miss_r points → score_l=3, state=4, game_over=1. Further misses give no change. A start edge clears scores and goes to state=1.
- Assert rst_n=0 mid-PLAY with score_l=2 → next cycle all outputs at reset values, state=0.
